// File: rtl/mioc_flop.sv
`default_nettype none
// ============================================================================
// Module      : mioc_flop
// Description : Single-bit MIOC storage register with load, set, clear,
//               toggle and hold; drives true and complementary outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module mioc_flop (
    input  logic clk,
    input  logic rst_n,
    input  logic in1,
    input  logic in2,
    input  logic in3,
    input  logic in4,
    output logic q,
    output logic qbar
);

    localparam logic [1:0] c_JK_HOLD   = 2'b00;
    localparam logic [1:0] c_JK_CLEAR  = 2'b01;
    localparam logic [1:0] c_JK_SET    = 2'b10;
    localparam logic [1:0] c_JK_TOGGLE = 2'b11;

    logic r_state;
    logic w_next;

    // J/K requests take priority; load/hold only applies when both are idle.
    always_comb begin
        w_next = r_state;
        case ({in3, in4})
            c_JK_TOGGLE: w_next = ~r_state;
            c_JK_SET:    w_next = 1'b1;
            c_JK_CLEAR:  w_next = 1'b0;
            c_JK_HOLD:   w_next = in2 ? in1 : r_state;
            default:     w_next = r_state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= 1'b0;
        end else begin
            r_state <= w_next;
        end
    end

    // Both outputs derive from the one register bit so they can never agree.
    assign q    = r_state;
    assign qbar = ~r_state;

endmodule
`default_nettype wire

// File: tb/tb_mioc_flop.sv
`default_nettype none
// ============================================================================
// Module      : tb_mioc_flop
// Description : Scoreboard bench for mioc_flop using directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mioc_flop;

    logic clk;
    logic rst_n;
    logic in1;
    logic in2;
    logic in3;
    logic in4;
    logic q;
    logic qbar;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   exp_q[$];
    event sample_ev;

    mioc_flop u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .in1  (in1),
        .in2  (in2),
        .in3  (in3),
        .in4  (in4),
        .q    (q),
        .qbar (qbar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops one expectation per falling edge, or on an explicit
    // mid-cycle sample request (used for asynchronous reset checks).
    initial begin
        bit e;
        forever begin
            @(negedge clk or sample_ev);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (q !== e) begin
                    n_fail++;
                    $display("FAIL q at %0t: got %b expected %b", $time, q, e);
                end
                n_checks++;
                if (qbar !== ~e) begin
                    n_fail++;
                    $display("FAIL qbar at %0t: got %b expected %b", $time, qbar, ~e);
                end
            end
        end
    end

    // Drive a pattern {in1,in2,in3,in4}, expect e after the next rising edge.
    task automatic apply(input logic [3:0] p, input bit e);
        {in1, in2, in3, in4} = p;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic sample_now(input bit e);
        exp_q.push_back(e);
        ->sample_ev;
        #1;
    endtask

    initial begin
        logic [15:0] sweep_from0;
        logic [15:0] sweep_from1;
        sweep_from0 = 16'hDCCC;
        sweep_from1 = 16'h5545;

        rst_n = 1'b0;
        {in1, in2, in3, in4} = 4'b1111;
        #1;
        sample_now(1'b0);

        // Reset held with toggle request and clock running
        @(negedge clk);
        #1;
        apply(4'b1111, 1'b0);
        apply(4'b1111, 1'b0);
        apply(4'b1111, 1'b0);
        rst_n = 1'b1;
        apply(4'b1111, 1'b1);

        // Load / hold
        apply(4'b0001, 1'b0);
        apply(4'b1100, 1'b1);
        apply(4'b0000, 1'b1);
        apply(4'b0000, 1'b1);
        apply(4'b0000, 1'b1);
        apply(4'b0100, 1'b0);
        apply(4'b1000, 1'b0);

        // Set / clear beat load
        apply(4'b0110, 1'b1);
        apply(4'b1101, 1'b0);

        // Toggle run
        apply(4'b0011, 1'b1);
        apply(4'b0011, 1'b0);
        apply(4'b0011, 1'b1);
        apply(4'b0011, 1'b0);

        // Async reset between edges while toggling
        apply(4'b0011, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        sample_now(1'b0);
        apply(4'b0011, 1'b0);
        rst_n = 1'b1;
        apply(4'b0011, 1'b1);

        // Exhaustive sweep from both start states
        for (int p = 0; p < 16; p++) begin
            apply(4'b0001, 1'b0);
            apply(p[3:0], sweep_from0[p]);
            apply(4'b0010, 1'b1);
            apply(p[3:0], sweep_from1[p]);
        end

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
